quad_tdm_mux: RTL and testbench

Four-channel time-division multiplexer: the sending end of the addressed single-line link whose receiving end is the 1-to-4 demultiplexer (`data` plus 2-bit `addr`, with `addr` 0/1/2/3 selecting A/B/C/D). The block latches strobed samples from channels A–D and arbitrates among pending channels round-robin. It presents one sample at a time as `{addr, data}` with a valid/ready handshake, so a downstream register stage or link can hold it off.

---
 rtl/quad_tdm_mux_pkg.sv | 17 +
 rtl/quad_tdm_mux_if.sv | 12 +
 rtl/quad_tdm_mux_rr_pick4.sv | 18 +
 rtl/quad_tdm_mux.sv | 122 ++++++++++++
 tb/tb_quad_tdm_mux.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_tdm_mux_pkg.sv
// Shared types and constants for the four-channel TDM sender.
package tdm_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  localparam logic [CH_W-1:0] CH_A = 2'd0;
  localparam logic [CH_W-1:0] CH_B = 2'd1;
  localparam logic [CH_W-1:0] CH_C = 2'd2;
  localparam logic [CH_W-1:0] CH_D = 2'd3;

endpackage

// File: rtl/quad_tdm_mux_if.sv
// Addressed single-line link: {addr, data} with valid/ready handshake.
interface quad_tdm_mux_if #(
  parameter int unsigned DWIDTH = 1
);
  logic [DWIDTH-1:0] data;
  logic [1:0]        addr;
  logic              valid;
  logic              ready;

  modport master (output data, output addr, output valid, input ready);
  modport slave  (input data, input addr, input valid, output ready);
endinterface

// File: rtl/quad_tdm_mux_rr_pick4.sv
// Round-robin picker: first pending channel at or after ptr, modulo 4.
module rr_pick4 (
  input  logic [3:0] pend,
  input  logic [1:0] ptr,
  output logic [1:0] grant_idx,
  output logic       any
);

  // Walk offsets from farthest to nearest so the nearest pending channel wins.
  always_comb begin
    grant_idx = ptr;
    any       = |pend;
    for (int k = 3; k >= 0; k--) begin
      if (pend[ptr + 2'(k)]) grant_idx = ptr + 2'(k);
    end
  end

endmodule

// File: rtl/quad_tdm_mux.sv
// Four-channel TDM sender: strobed capture, round-robin arbitration, valid/ready output.
module quad_tdm_mux
  import tdm_pkg::*;
#(
  parameter int unsigned DWIDTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  input  logic [DWIDTH-1:0] C,
  input  logic [DWIDTH-1:0] D,
  input  logic [3:0]        strb,
  input  logic              clr_overrun,
  output logic [3:0]        overrun,
  quad_tdm_mux_if.master    bus
);

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [DWIDTH-1:0] hold_q [NUM_CH];
  logic [DWIDTH-1:0] hold_d [NUM_CH];
  logic [DWIDTH-1:0] samp   [NUM_CH];
  logic [3:0]        pend_q, pend_d;
  logic [3:0]        ovr_q, ovr_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [1:0]        addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [1:0]        grant_idx_c;
  logic              any_c;
  logic              load_c;

  assign samp[0] = A;
  assign samp[1] = B;
  assign samp[2] = C;
  assign samp[3] = D;

  rr_pick4 u_pick (
    .pend      (pend_q),
    .ptr       (ptr_q),
    .grant_idx (grant_idx_c),
    .any       (any_c)
  );

  // Next state and output-register values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_c) begin
          load_c  = 1'b1;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.ready) begin
          if (any_c) begin
            load_c = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_c) begin
      data_d = hold_q[grant_idx_c];
      addr_d = grant_idx_c;
      ptr_d  = grant_idx_c + 2'd1;
    end
  end

  // Capture, pending and overrun update; a strobe on the grant edge refills without overrun.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hold_d[i] = hold_q[i];
      pend_d[i] = pend_q[i];
      ovr_d[i]  = ovr_q[i] & ~clr_overrun;
      if (load_c && (grant_idx_c == 2'(i))) pend_d[i] = 1'b0;
      if (strb[i]) begin
        hold_d[i] = samp[i];
        pend_d[i] = 1'b1;
        if (pend_q[i] && !(load_c && (grant_idx_c == 2'(i)))) ovr_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= CH_A;
      pend_q  <= '0;
      ovr_q   <= '0;
      data_q  <= '0;
      addr_q  <= CH_A;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign bus.data  = data_q;
  assign bus.addr  = addr_q;
  assign bus.valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_quad_tdm_mux.sv
// Directed self-checking bench for quad_tdm_mux.
module tb_quad_tdm_mux;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic [3:0] strb = '0;
  logic       clr_overrun = 1'b0;
  logic [3:0] overrun;
  int         ncmp = 0;
  int         nfail = 0;

  quad_tdm_mux_if #(.DWIDTH(1)) bus ();

  quad_tdm_mux #(.DWIDTH(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .A           (a),
    .B           (b),
    .C           (c),
    .D           (d),
    .strb        (strb),
    .clr_overrun (clr_overrun),
    .overrun     (overrun),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    strb = '0;
    clr_overrun = 1'b0;
    bus.ready = 1'b0;
    {a, b, c, d} = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.ready = 1'b0;
    #2;
    ncmp++;
    if ({bus.valid, bus.addr, bus.data, overrun} !== 8'b0) begin
      nfail++;
      $display("FAIL reset_state: got v/a/d/ovr=%b/%0d/%b/%b want 0/0/0/0000", bus.valid, bus.addr, bus.data, overrun);
    end
  endtask

  task automatic test_single;
    do_reset();
    bus.ready = 1'b1;
    a = 1'b1; strb = 4'b0001;
    tick();
    strb = '0;
    ncmp++;
    if (bus.valid !== 1'b0) begin
      nfail++; $display("FAIL single_latency: got valid=%b want 0", bus.valid);
    end
    tick();
    ncmp++;
    if ({bus.valid, bus.addr, bus.data} !== {1'b1, 2'd0, 1'b1}) begin
      nfail++; $display("FAIL single_out: got v/a/d=%b/%0d/%b want 1/0/1", bus.valid, bus.addr, bus.data);
    end
    tick();
    ncmp++;
    if (bus.valid !== 1'b0) begin
      nfail++; $display("FAIL single_drop: got valid=%b want 0", bus.valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_addr [4];
    logic       exp_data [4];
    exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_data = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    bus.ready = 1'b1;
    {a, b, c, d} = 4'b1011;
    strb = 4'b1111;
    tick();
    strb = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      ncmp++;
      if ({bus.valid, bus.addr, bus.data} !== {1'b1, exp_addr[k], exp_data[k]}) begin
        nfail++;
        $display("FAIL b2b_%0d: got v/a/d=%b/%0d/%b want 1/%0d/%b", k, bus.valid, bus.addr, bus.data, exp_addr[k], exp_data[k]);
      end
    end
    tick();
    ncmp++;
    if (bus.valid !== 1'b0) begin
      nfail++; $display("FAIL b2b_end: got valid=%b want 0", bus.valid);
    end
  endtask

  task automatic test_stall;
    do_reset();
    c = 1'b1; strb = 4'b0100;
    tick();
    strb = '0;
    tick();
    c = 1'b0; b = 1'b0; d = 1'b1; strb = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      tick();
      strb = '0;
      ncmp++;
      if ({bus.valid, bus.addr, bus.data} !== {1'b1, 2'd2, 1'b1}) begin
        nfail++;
        $display("FAIL stall_hold_%0d: got v/a/d=%b/%0d/%b want 1/2/1", k, bus.valid, bus.addr, bus.data);
      end
    end
    bus.ready = 1'b1;
    tick();
    ncmp++;
    if ({bus.valid, bus.addr, bus.data} !== {1'b1, 2'd3, 1'b1}) begin
      nfail++; $display("FAIL stall_d_first: got v/a/d=%b/%0d/%b want 1/3/1", bus.valid, bus.addr, bus.data);
    end
    tick();
    ncmp++;
    if ({bus.valid, bus.addr, bus.data} !== {1'b1, 2'd1, 1'b0}) begin
      nfail++; $display("FAIL stall_b_next: got v/a/d=%b/%0d/%b want 1/1/0", bus.valid, bus.addr, bus.data);
    end
    tick();
    ncmp++;
    if ({bus.valid, overrun} !== 5'b0) begin
      nfail++; $display("FAIL stall_end: got valid/ovr=%b/%b want 0/0000", bus.valid, overrun);
    end
  endtask

  task automatic test_overrun;
    do_reset();
    a = 1'b1; strb = 4'b0001;
    tick();
    strb = '0;
    tick();
    b = 1'b0; strb = 4'b0010;
    tick();
    ncmp++;
    if (overrun !== 4'b0000) begin
      nfail++; $display("FAIL ovr_first: got overrun=%b want 0000", overrun);
    end
    b = 1'b1; strb = 4'b0010;
    tick();
    strb = '0;
    ncmp++;
    if (overrun !== 4'b0010) begin
      nfail++; $display("FAIL ovr_set: got overrun=%b want 0010", overrun);
    end
    bus.ready = 1'b1;
    tick();
    ncmp++;
    if ({bus.valid, bus.addr, bus.data} !== {1'b1, 2'd1, 1'b1}) begin
      nfail++; $display("FAIL ovr_newest: got v/a/d=%b/%0d/%b want 1/1/1", bus.valid, bus.addr, bus.data);
    end
    repeat (2) begin
      tick();
      ncmp++;
      if ({bus.valid, overrun} !== 5'b0_0010) begin
        nfail++; $display("FAIL ovr_single_b: got valid/ovr=%b/%b want 0/0010", bus.valid, overrun);
      end
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    ncmp++;
    if (overrun !== 4'b0000) begin
      nfail++; $display("FAIL ovr_clear: got overrun=%b want 0000", overrun);
    end
  endtask

  task automatic test_set_wins;
    do_reset();
    a = 1'b1; strb = 4'b0001;
    tick();
    strb = '0;
    tick();
    strb = 4'b1010;
    tick();
    strb = 4'b0010;
    tick();
    ncmp++;
    if (overrun !== 4'b0010) begin
      nfail++; $display("FAIL setwins_pre: got overrun=%b want 0010", overrun);
    end
    strb = 4'b1000; clr_overrun = 1'b1;
    tick();
    strb = '0; clr_overrun = 1'b0;
    ncmp++;
    if (overrun !== 4'b1000) begin
      nfail++; $display("FAIL setwins: got overrun=%b want 1000", overrun);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.ready = 1'b1;
    {a, b, c} = 3'b111; strb = 4'b0111;
    tick();
    strb = '0;
    tick();
    ncmp++;
    if ({bus.valid, bus.addr, bus.data} !== {1'b1, 2'd0, 1'b1}) begin
      nfail++; $display("FAIL rstmid_pre: got v/a/d=%b/%0d/%b want 1/0/1", bus.valid, bus.addr, bus.data);
    end
    #2 reset = 1'b1;
    #1;
    ncmp++;
    if ({bus.valid, bus.addr, bus.data, overrun} !== 8'b0) begin
      nfail++; $display("FAIL rstmid_async: got v/a/d/ovr=%b/%0d/%b/%b want 0/0/0/0000", bus.valid, bus.addr, bus.data, overrun);
    end
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      ncmp++;
      if (bus.valid !== 1'b0) begin
        nfail++; $display("FAIL rstmid_flushed_%0d: got valid=%b want 0", k, bus.valid);
      end
    end
    d = 1'b1; strb = 4'b1000;
    tick();
    strb = '0;
    tick();
    ncmp++;
    if ({bus.valid, bus.addr, bus.data} !== {1'b1, 2'd3, 1'b1}) begin
      nfail++; $display("FAIL rstmid_new: got v/a/d=%b/%0d/%b want 1/3/1", bus.valid, bus.addr, bus.data);
    end
  endtask

  initial begin
    bus.ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overrun();
    test_set_wins();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
